// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control FSM and its ALU decoder.
// Latency: none (definitions only). Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_BRLINK   = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_PC        = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b001;
    localparam logic [2:0] SH_ASR = 3'b010;
    localparam logic [2:0] SH_ROR = 3'b011;
    localparam logic [2:0] SH_RRX = 3'b100;

    // sh_field is instr[11:4]: shamt5, sh type, register-shift flag.
    // ROR by immediate zero is the architectural encoding of RRX.
    function automatic logic [2:0] shift_decode(input logic [7:0] sh_field);
        logic [2:0] op;
        op = {1'b0, sh_field[2:1]};
        if (sh_field[2:1] == 2'b11 && !sh_field[0] && sh_field[7:3] == 5'd0) begin
            op = SH_RRX;
        end
        return op;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Data-processing decode: Funct/Src2 to ALUControl, FlagW and ShiftOp; ADD/no-flags when idle.
// Latency: combinational. Backpressure: none.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic        ALUOp,
    input  logic        ShiftEn,
    input  logic [5:0]  Funct,
    input  logic [11:0] Src2,
    output logic [3:0]  ALUControl,
    output logic [1:0]  FlagW,
    output logic [2:0]  ShiftOp
);

    logic [3:0] cmd;
    logic       unused_bits;

    assign cmd         = Funct[4:1];
    assign unused_bits = Funct[5] ^ (^Src2[3:0]);

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        ShiftOp    = SH_LSL;
        if (ALUOp) begin
            ALUControl = cmd;
            FlagW[1]   = Funct[0];
            // cmd[3] only separates the compare forms (TST/CMP) from AND/SUB,
            // so the compares update C/V exactly like their base operations.
            FlagW[0]   = Funct[0] & ((cmd[2:0] == 3'b000) | (cmd[2:0] == 3'b010));
            if (ShiftEn) begin
                ShiftOp = shift_decode(Src2[11:4]);
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM (3-5 cycles/instr); optional BL link state via MCCTRL_BRANCH_LINK_EN.
// Latency: outputs combinational from state and inputs; one state per clk.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until MemReady.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic [11:0] Src2,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        NextPC,
    output logic        RegW,
    output logic        MemW,
    output logic        PCS,
    output logic [3:0]  ALUControl,
    output logic [1:0]  FlagW,
    output logic [2:0]  ShiftOp,
    output logic        Undef,
    output logic [3:0]  State
`ifdef MCCTRL_BRANCH_LINK_EN
    ,
    output logic        LinkW
`endif
);

    state_t state_q, state_d;
    logic   alu_op;
    logic   shift_en;
    logic   rd_is_pc;

    assign rd_is_pc = (Rd == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_RN;
        ALUSrcB   = SRCB_RM;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        PCS       = 1'b0;
        Undef     = 1'b0;
        alu_op    = 1'b0;
        shift_en  = 1'b0;
`ifdef MCCTRL_BRANCH_LINK_EN
        LinkW     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+8 lands in ALUOut for later use as the R15 read value
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10: begin
`ifdef MCCTRL_BRANCH_LINK_EN
                        state_d = Funct[4] ? S_BRLINK : S_BRANCH;
`else
                        state_d = S_BRANCH;
`endif
                    end
                    default: begin
                        Undef   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
                PCS       = rd_is_pc;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcB  = SRCB_RM;
                alu_op   = 1'b1;
                shift_en = 1'b1;
                state_d  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                // TST/TEQ/CMP/CMN only set flags
                ResultSrc = RES_ALUOUT;
                RegW      = (Funct[4:3] != 2'b10);
                PCS       = (Funct[4:3] != 2'b10) & rd_is_pc;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCS       = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MCCTRL_BRANCH_LINK_EN
            S_BRLINK: begin
                // writes the return address into R14 before the branch target
                ResultSrc = RES_PC;
                RegW      = 1'b1;
                LinkW     = 1'b1;
                state_d   = S_BRANCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .ShiftEn    (shift_en),
        .Funct      (Funct),
        .Src2       (Src2),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .ShiftOp    (ShiftOp)
    );

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign State  = state_q;

endmodule
